// File: rtl/fifo_n.sv
// N-entry FIFO with guarded enq/deq/first/clear methods, occupancy count,
// almost-full flag and a sticky protocol-error flag.
module fifo_n #(
  parameter int WIDTH    = 128,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_enq__ENA,
  input  logic [WIDTH-1:0]           in_enq_v,
  output logic                       in_enq__RDY,
  input  logic                       out_deq__ENA,
  output logic                       out_deq__RDY,
  output logic [WIDTH-1:0]           out_first,
  output logic                       out_first__RDY,
  input  logic                       clear__ENA,
  output logic                       clear__RDY,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             enq_fire;
  logic             deq_fire;
  logic             violation;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_enq__RDY    = (count < CW'(DEPTH));
  assign out_deq__RDY   = (count != '0);
  assign out_first__RDY = out_deq__RDY;
  assign out_first      = mem[rd_ptr];
  assign clear__RDY     = 1'b1;
  assign almost_full    = (count >= CW'(AF_LEVEL));

  assign enq_fire  = in_enq__ENA & in_enq__RDY & ~clear__ENA;
  assign deq_fire  = out_deq__ENA & out_deq__RDY & ~clear__ENA;
  assign violation = ~clear__ENA &
                     ((in_enq__ENA & ~in_enq__RDY) | (out_deq__ENA & ~out_deq__RDY));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (clear__ENA) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= ptr_next(wr_ptr);
      if (deq_fire) rd_ptr <= ptr_next(rd_ptr);
      if (enq_fire && !deq_fire)
        count <= count + CW'(1);
      else if (deq_fire && !enq_fire)
        count <= count - CW'(1);
      if (violation) err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (enq_fire) mem[wr_ptr] <= in_enq_v;
  end

endmodule

// File: tb/tb_fifo_n.sv
// Directed bench for fifo_n: a queue-based reference model checked every
// cycle, plus literal expectations for the depth-4 and depth-5 scenarios.
module tb_fifo_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instance A: WIDTH 128, DEPTH 4
  logic         a_rst = 1'b1;
  logic         a_enq_ena = 1'b0, a_deq_ena = 1'b0, a_clear = 1'b0;
  logic [127:0] a_enq_v = '0;
  logic         a_enq_rdy, a_deq_rdy, a_first_rdy, a_clear_rdy, a_af, a_err;
  logic [127:0] a_first;
  logic [2:0]   a_count;

  fifo_n #(.WIDTH(128), .DEPTH(4)) u_a (
    .CLK(clk), .RST(a_rst),
    .in_enq__ENA(a_enq_ena), .in_enq_v(a_enq_v), .in_enq__RDY(a_enq_rdy),
    .out_deq__ENA(a_deq_ena), .out_deq__RDY(a_deq_rdy),
    .out_first(a_first), .out_first__RDY(a_first_rdy),
    .clear__ENA(a_clear), .clear__RDY(a_clear_rdy),
    .count(a_count), .almost_full(a_af), .err(a_err)
  );

  // Instance B: WIDTH 16, DEPTH 5
  logic        b_rst = 1'b1;
  logic        b_enq_ena = 1'b0, b_deq_ena = 1'b0, b_clear = 1'b0;
  logic [15:0] b_enq_v = '0;
  logic        b_enq_rdy, b_deq_rdy, b_first_rdy, b_clear_rdy, b_af, b_err;
  logic [15:0] b_first;
  logic [2:0]  b_count;

  fifo_n #(.WIDTH(16), .DEPTH(5)) u_b (
    .CLK(clk), .RST(b_rst),
    .in_enq__ENA(b_enq_ena), .in_enq_v(b_enq_v), .in_enq__RDY(b_enq_rdy),
    .out_deq__ENA(b_deq_ena), .out_deq__RDY(b_deq_rdy),
    .out_first(b_first), .out_first__RDY(b_first_rdy),
    .clear__ENA(b_clear), .clear__RDY(b_clear_rdy),
    .count(b_count), .almost_full(b_af), .err(b_err)
  );

  // Reference model: contents as a queue, error as a flag.
  logic [127:0] qa[$];
  logic [15:0]  qb[$];
  bit ea = 1'b0, eb = 1'b0;
  bit a_ef, a_df, b_ef, b_df;

  always @(posedge clk or posedge a_rst) begin
    if (a_rst || a_clear) begin
      qa.delete();
      ea = 1'b0;
    end else begin
      a_ef = a_enq_ena && (qa.size() < 4);
      a_df = a_deq_ena && (qa.size() > 0);
      if ((a_enq_ena && !a_ef) || (a_deq_ena && !a_df)) ea = 1'b1;
      if (a_df) void'(qa.pop_front());
      if (a_ef) qa.push_back(a_enq_v);
    end
  end

  always @(posedge clk or posedge b_rst) begin
    if (b_rst || b_clear) begin
      qb.delete();
      eb = 1'b0;
    end else begin
      b_ef = b_enq_ena && (qb.size() < 5);
      b_df = b_deq_ena && (qb.size() > 0);
      if ((b_enq_ena && !b_ef) || (b_deq_ena && !b_df)) eb = 1'b1;
      if (b_df) void'(qb.pop_front());
      if (b_ef) qb.push_back(b_enq_v);
    end
  end

  always @(negedge clk) begin
    chk("a_count", a_count, qa.size());
    chk("a_enq_rdy", a_enq_rdy, qa.size() < 4);
    chk("a_deq_rdy", a_deq_rdy, qa.size() > 0);
    chk("a_first_rdy", a_first_rdy, qa.size() > 0);
    chk("a_af", a_af, qa.size() >= 3);
    chk("a_err", a_err, ea);
    chk("a_clear_rdy", a_clear_rdy, 1'b1);
    if (qa.size() > 0) chk("a_first", a_first, qa[0]);
    chk("b_count", b_count, qb.size());
    chk("b_enq_rdy", b_enq_rdy, qb.size() < 5);
    chk("b_deq_rdy", b_deq_rdy, qb.size() > 0);
    chk("b_af", b_af, qb.size() >= 4);
    chk("b_err", b_err, eb);
    if (qb.size() > 0) chk("b_first", b_first, 128'(qb[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_enq(input logic [127:0] v);
    a_enq_ena = 1'b1;
    a_enq_v   = v;
    step();
    a_enq_ena = 1'b0;
  endtask

  task automatic a_deq();
    a_deq_ena = 1'b1;
    step();
    a_deq_ena = 1'b0;
  endtask

  task automatic a_clr();
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_count", a_count, 0);
    chk("rst_enq_rdy", a_enq_rdy, 1);
    chk("rst_deq_rdy", a_deq_rdy, 0);
    chk("rst_first_rdy", a_first_rdy, 0);
    chk("rst_af", a_af, 0);
    chk("rst_err", a_err, 0);
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Fill to full, then drain in order
    for (int i = 1; i <= 4; i++) begin
      a_enq(128'(i));
      chk("fill_count", a_count, i);
      chk("fill_af", a_af, i >= 3);
    end
    chk("full_enq_rdy", a_enq_rdy, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_first", a_first, i);
      a_deq();
    end
    chk("empty_deq_rdy", a_deq_rdy, 0);
    chk("empty_count", a_count, 0);

    // Overflow while full, then clear
    for (int i = 0; i < 4; i++) a_enq(128'h10 + 128'(i));
    a_enq(128'hDEAD);
    chk("ovf_err", a_err, 1);
    chk("ovf_count", a_count, 4);
    chk("ovf_first", a_first, 128'h10);
    a_clr();
    chk("clr_count", a_count, 0);
    chk("clr_err", a_err, 0);
    chk("clr_enq_rdy", a_enq_rdy, 1);

    // Underflow, then enq colliding with clear
    a_deq();
    chk("udf_err", a_err, 1);
    chk("udf_count", a_count, 0);
    a_enq_ena = 1'b1;
    a_enq_v   = 128'h7;
    a_clear   = 1'b1;
    step();
    a_enq_ena = 1'b0;
    a_clear   = 1'b0;
    chk("clrenq_count", a_count, 0);
    chk("clrenq_first_rdy", a_first_rdy, 0);
    chk("clrenq_err", a_err, 0);

    // No bypass: data visible only after the enq edge
    a_enq_ena = 1'b1;
    a_enq_v   = 128'hAB;
    #1;
    chk("lat_before", a_first_rdy, 0);
    @(posedge clk);
    #1;
    a_enq_ena = 1'b0;
    chk("lat_after_rdy", a_first_rdy, 1);
    chk("lat_after_data", a_first, 128'hAB);
    a_deq();

    // Asynchronous reset mid-cycle with two entries held
    a_enq(128'h1);
    a_enq(128'h2);
    chk("pre_rst_count", a_count, 2);
    #2;
    a_rst = 1'b1;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_deq_rdy", a_deq_rdy, 0);
    chk("arst_enq_rdy", a_enq_rdy, 1);
    step();
    a_rst = 1'b0;
    a_enq(128'h55);
    chk("post_rst_first", a_first, 128'h55);
    chk("post_rst_rdy", a_first_rdy, 1);
    a_deq();

    // Depth 5: steady count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      b_enq_ena = 1'b1;
      b_enq_v   = 16'(i);
      step();
    end
    b_deq_ena = 1'b1;
    for (int i = 2; i < 14; i++) begin
      chk("b_wrap_first", b_first, i - 2);
      b_enq_v = 16'(i);
      step();
      chk("b_wrap_count", b_count, 2);
    end
    b_enq_ena = 1'b0;
    for (int i = 12; i < 14; i++) begin
      chk("b_tail_first", b_first, i);
      step();
    end
    b_deq_ena = 1'b0;
    chk("b_final_count", b_count, 0);
    chk("b_final_err", b_err, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
